// File: rtl/ram_ctrl_rw_if.sv
// ram_ctrl_rw_if: request/response bus of the ram_ctrl_rw storage block.
// The master issues read/write requests and consumes read responses.
// The slave (the RAM controller) accepts requests, returns read data and
// reports busy while its post-reset clear sequence runs.
interface ram_ctrl_rw_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    // Request channel.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Read-response channel.
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // Status.
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/ram_ctrl_rw.sv
// ram_ctrl_rw: single-port synchronous RAM behind a valid/ready request port.
// - After reset, a clear sequence writes zero to every word, one word per cycle.
// - Reads return data one cycle after acceptance on a registered response
//   port that holds its data under backpressure.
// - Compile-time option RAM_PARITY_EN stores an even-parity bit with each
//   word and flags a mismatch on read through rsp_err.
module ram_ctrl_rw #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    ram_ctrl_rw_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic [WORD_W-1:0]     mem [DEPTH];

    logic                  req_ready;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [WORD_W-1:0]     rd_word;
    logic [WORD_W-1:0]     wr_word;
    logic                  rd_err;

    // A request may be taken once cleared, unless a held response is still
    // waiting for its consumer (accepting a read then would overwrite it).
    assign req_ready = (state_q == ST_IDLE) && !(rsp_valid_q && !bus.rsp_ready);

    // Requests seen during the reset cycle are dropped.
    assign rd_fire = !reset && bus.req_valid && req_ready && !bus.req_we;
    assign wr_fire = !reset && bus.req_valid && req_ready &&  bus.req_we;

    assign rd_word = mem[bus.req_addr];

`ifdef RAM_PARITY_EN
    assign wr_word = {^bus.req_wdata, bus.req_wdata};
    assign rd_err  = rd_word[DATA_WIDTH] != ^rd_word[DATA_WIDTH-1:0];
`else
    assign wr_word = bus.req_wdata;
    assign rd_err  = 1'b0;
`endif

    // Storage write port: zero fill during clear, otherwise accepted writes.
    // NOTE: the array itself has no reset; the clear sequence zeroes it,
    // which keeps it mappable to RAM macros and allows hierarchical deposits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_addr_q] <= '0;
            end else if (wr_fire) begin
                mem[bus.req_addr] <= wr_word;
            end
        end
    end

    // Clear/idle sequencing and the registered read-response channel.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (&clr_addr_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (rd_fire) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rd_word[DATA_WIDTH-1:0];
                        rsp_err_q   <= rd_err;
                    end else if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_ram_ctrl_rw.sv
// tb_ram_ctrl_rw: directed scenarios followed by random traffic, all checked
// every cycle against a behavioural model of the RAM (word array, pending
// response, remaining clear cycles). Build with +define+RAM_PARITY_EN to
// include the parity-corruption scenario.
module tb_ram_ctrl_rw;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic reset;

    ram_ctrl_rw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_ctrl_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [DW-1:0] mem_m [DEPTH];
    logic          bad_m [DEPTH];
    int            clr_left_m;
    logic          v_m;
    logic [DW-1:0] rdata_m;
    logic          err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 1'b0;
        end
        clr_left_m = DEPTH;
        v_m        = 1'b0;
        rdata_m    = '0;
        err_m      = 1'b0;
    endtask

    // One clock cycle: drive inputs, check all outputs, then advance the model.
    task automatic step(input logic rst, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic rr);
        logic busy_e;
        logic ready_e;
        @(negedge clk);
        reset         = rst;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.rsp_ready = rr;
        #1;
        busy_e  = clr_left_m > 0;
        ready_e = !busy_e && !(v_m && !rr);
        check("busy",      32'(bus.busy),      32'(busy_e));
        check("req_ready", 32'(bus.req_ready), 32'(ready_e));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(v_m));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(rdata_m));
        check("rsp_err",   32'(bus.rsp_err),   32'(err_m));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (busy_e) begin
            clr_left_m--;
        end else begin
            if (v_m && rr) v_m = 1'b0;
            if (v && ready_e) begin
                if (we) begin
                    mem_m[a] = wd;
                    bad_m[a] = 1'b0;
                end else begin
                    v_m     = 1'b1;
                    rdata_m = mem_m[a];
                    err_m   = bad_m[a];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        model_reset();

        // Reset, then a read of address 5 held through the clear.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 4'd5, '0, 1'b1);
        idle(2);

        // Write then immediately read the same address.
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd3, '0,    1'b1);
        idle(2);

        // Back-to-back reads under backpressure.
        step(1'b0, 1'b1, 1'b1, 4'd1, 8'h11, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'd2, 8'h22, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'h33, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b1);
        idle(2);

        // Fill with 0xFF, reset, interrupt the clear at cycle 7, then read all.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, AW'(i), 8'hFF, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(7);
        step(1'b1, 1'b1, 1'b1, 4'd4, 8'hFF, 1'b1);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1);
        idle(2);

`ifdef RAM_PARITY_EN
        // Corrupt the data bits of a stored word and read it back.
        step(1'b0, 1'b1, 1'b1, 4'd9, 8'h0F, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'd8, 8'h0F, 1'b1);
        @(negedge clk);
        dut.mem[9][DW-1:0] = 8'h0E;
        bad_m[9] = (^8'h0E) != (^8'h0F);
        mem_m[9] = 8'h0E;
        step(1'b0, 1'b1, 1'b0, 4'd9, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd8, '0, 1'b1);
        idle(2);
`endif

        // Reset while a response is pending and stalled.
        step(1'b0, 1'b1, 1'b1, 4'd6, 8'h5A, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd6, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd6, '0, 1'b0);
        idle(DEPTH + 3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 400) == 0, 1'($urandom), 1'($urandom),
                 AW'($urandom), DW'($urandom), ($urandom % 4) != 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_ctrl_rw.md
# ram_ctrl_rw

Parametrised single-port synchronous RAM with a valid/ready request port, a registered read-response port with backpressure, and a hardware clear sequence that zeroes every word after reset. It replaces the fixed 2-bit-address, 4-bit-data read/write RAM as the general storage block behind the datapath and register-file experiments. Optional per-word parity is selected at compile time.

## Interface
- ADDR_WIDTH, 4, address bits; depth is fixed at DEPTH = 2**ADDR_WIDTH words (localparam).
- DATA_WIDTH, 8, bits per word (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  parity mismatch on this response; valid only with rsp_valid.
- busy  out  1  clear sequence in progress.

## Operation
- States: CLEAR and IDLE.
- Reset forces CLEAR and sets clr_addr=0. It also sets rsp_valid=0, rsp_rdata=0 and rsp_err=0.
- CLEAR: each cycle writes 0 to mem[clr_addr], then clr_addr increments.
  - After the write to DEPTH-1, the state moves to IDLE.
  - busy=1 and req_ready=0 throughout CLEAR.
- IDLE: busy=0. req_ready = !(rsp_valid && !rsp_ready), combinational from state and rsp_ready.
- Accepted write: mem[req_addr] <= req_wdata at that edge. No response is generated, and rsp_* are unaffected.
- Accepted read: at that edge, rsp_rdata <= mem[req_addr], rsp_err is computed, and rsp_valid <= 1.
- rsp_valid clears on an edge where rsp_valid && rsp_ready and no new read is accepted.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable and req_ready=0. Requests are neither lost nor reordered.
- A read in the cycle after a write to the same address returns the new data.
- Reads of unwritten words return 0, because of the clear sequence.
- The address is used modulo DEPTH, so no out-of-range handling is needed.
- rsp_rdata keeps its last value while rsp_valid=0.

## Timing
- Clear duration: exactly DEPTH cycles with reset low. busy falls, and req_ready may rise, on cycle DEPTH after reset deasserts.
- Read latency is 1 cycle: a read accepted at edge N gives rsp_valid=1 after edge N.
- Throughput with rsp_ready held high is one request per cycle. Reads and writes may be freely interleaved.
- Response handoff and a new read may occur on the same edge: rsp_valid stays 1 and rsp_rdata updates to the new word.
- Reset asserted mid-clear or mid-traffic:
  - The clear restarts from address 0.
  - A pending response is discarded (rsp_valid=0).
  - A request presented in the reset cycle is ignored.
- Storage must be a plain array named mem, so that benches can deposit into it hierarchically.

## Configuration
- RAM_PARITY_EN defined:
  - Each word stores DATA_WIDTH+1 bits, with parity bit = ^data (even parity).
  - Writes and the clear sequence store consistent parity; the clear stores parity 0.
  - On read, rsp_err = stored parity != ^stored data.
- RAM_PARITY_EN undefined:
  - Words are DATA_WIDTH bits and rsp_err is constant 0.
  - All other behaviour is identical.

## Test plan
- Reset 1 cycle, then req_valid held high: busy=1 and req_ready=0 for 16 cycles (defaults), then busy=0 and req_ready=1. A read of address 5 returns 0x00 one cycle after acceptance.
- Write 0xA5 to address 3, then read address 3 on the next cycle: rsp_rdata=0xA5 and rsp_valid=1 for one cycle.
- Back-to-back reads of addresses 1, 2, 3 with rsp_ready=0 from the first response: rsp_rdata holds the address-1 data and req_ready=0. After rsp_ready=1, the responses for 2 and 3 follow on consecutive cycles, in order.
- Reset asserted at clear cycle 7: busy stays high for a further 16 cycles after deassertion. Every address reads 0, including those previously written with 0xFF.
- With RAM_PARITY_EN: write 0x0F to address 9, deposit 0x0E into the data bits of mem[9], read address 9 → rsp_err=1. Address 8 reads with rsp_err=0.
- Reset with rsp_valid=1 pending: rsp_valid=0 the cycle after the reset edge, and no stale response appears after the clear completes.
